// File: rtl/pool_restream_pkg.sv
// Shared state encoding, sizing helper and constants for the pooled-pixel restreamer.
package pool_restream_pkg;

  localparam int unsigned DROP_CNT_BITW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so the result can size a vector directly.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/restream_fifo.sv
// Synchronous FIFO with registered read data; a pop on empty returns all-zero data.
module restream_fifo
  import pool_restream_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [0:DATA_W-1]      wdata,
  output logic [0:DATA_W-1]      rdata,
  output logic [log2(DEPTH):0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = log2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [0:DATA_W-1] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr_c;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:DATA_W-1] rdata_q, rdata_d;
  logic              do_push_c, do_pop_c;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = rdata_q;

  always_comb begin
    do_pop_c  = pop && !empty;
    // A full FIFO still takes a push when an entry leaves, or is flushed, the same cycle.
    do_push_c = push && (!full || do_pop_c || flush);
    wr_addr_c = flush ? '0 : wr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = PTR_W'(do_push_c);
      count_d  = CNT_W'(do_push_c);
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
    if (pop) rdata_d = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_addr_c] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/pool_restreamer.sv
// Buffers sparse pooled pixels and re-issues them as a dense half-resolution raster.
// Optional saturating drop counter when POOL_RESTREAM_DROP_COUNT_EN is defined.
module pool_restreamer
  import pool_restream_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned HEIGHT     = 64,
  parameter int unsigned O_W_WIDTH  = 40,
  parameter int unsigned O_W_HEIGHT = 36,
  parameter int unsigned FIXED_BITW = 16,
  parameter int unsigned UNITS      = 4,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PRELOAD    = 8
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic                              in_enable,
  input  logic [0:FIXED_BITW*UNITS-1]       in_pixels,
  input  logic [log2(HEIGHT/2)-1:0]         in_vcnt,
  input  logic [log2(WIDTH/2)-1:0]          in_hcnt,
  output logic                              out_enable,
  output logic [0:FIXED_BITW*UNITS-1]       out_pixels,
  output logic [log2(O_W_HEIGHT)-1:0]       out_vcnt,
  output logic [log2(O_W_WIDTH)-1:0]        out_hcnt,
  output logic                              overflow,
  output logic                              underflow,
  output logic [DROP_CNT_BITW-1:0]          drop_count
);

  localparam int unsigned PIX_W = FIXED_BITW * UNITS;
  localparam int unsigned OV_W  = log2(O_W_HEIGHT);
  localparam int unsigned OH_W  = log2(O_W_WIDTH);
  localparam int unsigned CNT_W = log2(FIFO_DEPTH) + 1;
  localparam int unsigned ACT_W = WIDTH / 2;
  localparam int unsigned ACT_H = HEIGHT / 2;

  state_e           state_q, state_d;
  logic [OH_W-1:0]  hcnt_q, hcnt_d, out_hcnt_q, out_hcnt_d;
  logic [OV_W-1:0]  vcnt_q, vcnt_d, out_vcnt_q, out_vcnt_d;
  logic             sof_pending_q, sof_pending_d;
  logic             out_enable_q, out_enable_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             sof_c, active_c, pop_c, flush_c, drop_c;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign sof_c    = in_enable && (in_vcnt == '0) && (in_hcnt == '0);
  assign active_c = (state_q == RUN) && (32'(hcnt_q) < ACT_W) && (32'(vcnt_q) < ACT_H);
  assign pop_c    = active_c;
  assign flush_c  = (state_q == WAIT) && sof_c;
  assign drop_c   = in_enable && fifo_full && !pop_c && !flush_c;

  restream_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (PIX_W)
  ) u_fifo (
    .clk   (clock),
    .rst   (rst),
    .push  (in_enable),
    .pop   (pop_c),
    .flush (flush_c),
    .wdata (in_pixels),
    .rdata (out_pixels),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencing and free-running output raster counters.
  always_comb begin
    state_d       = state_q;
    sof_pending_d = sof_pending_q;
    hcnt_d        = '0;
    vcnt_d        = '0;
    unique case (state_q)
      IDLE: if (sof_c) state_d = WAIT;
      WAIT: if (32'(fifo_count) >= PRELOAD) state_d = RUN;
      RUN: begin
        hcnt_d = hcnt_q + OH_W'(1);
        vcnt_d = vcnt_q;
        if (sof_c) sof_pending_d = 1'b1;
        if (hcnt_q == OH_W'(O_W_WIDTH - 1)) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + OV_W'(1);
          if (vcnt_q == OV_W'(O_W_HEIGHT - 1)) begin
            vcnt_d        = '0;
            // An SOF on the final cycle still counts as pending.
            state_d       = (sof_pending_q || sof_c) ? WAIT : IDLE;
            sof_pending_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_enable_d = active_c;
    out_hcnt_d   = hcnt_q;
    out_vcnt_d   = vcnt_q;
    overflow_d   = overflow_q | drop_c;
    underflow_d  = underflow_q | (pop_c & fifo_empty);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      sof_pending_q <= 1'b0;
      out_enable_q  <= 1'b0;
      out_hcnt_q    <= '0;
      out_vcnt_q    <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      sof_pending_q <= sof_pending_d;
      out_enable_q  <= out_enable_d;
      out_hcnt_q    <= out_hcnt_d;
      out_vcnt_q    <= out_vcnt_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign out_enable = out_enable_q;
  assign out_hcnt   = out_hcnt_q;
  assign out_vcnt   = out_vcnt_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

`ifdef POOL_RESTREAM_DROP_COUNT_EN
  logic [DROP_CNT_BITW-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_BITW'(1);
  end

  always_ff @(posedge clock) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pool_restreamer.sv
// Directed bench: a rate-matched full-frame instance and a small-FIFO instance for corner cases.
module tb_pool_restreamer;
  import pool_restream_pkg::*;

  typedef struct {
    logic        sof_first;
    int unsigned n_push;
    state_e      exp_state;
    int unsigned exp_count;
    logic        exp_ovf;
    int unsigned exp_drops_en;
  } burst_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_en, m_oe, m_ovf, m_unf;
  logic [0:63] m_pix, m_opix;
  logic [4:0]  m_vcnt, m_hcnt;
  logic [5:0]  m_ov;
  logic [6:0]  m_oh;
  logic [15:0] m_drop;

  logic        s_en, s_oe, s_ovf, s_unf;
  logic [0:63] s_pix, s_opix;
  logic [4:0]  s_vcnt, s_hcnt;
  logic [5:0]  s_ov, s_oh;
  logic [15:0] s_drop;

  int checks = 0;
  int errors = 0;

  pool_restreamer #(
    .WIDTH(64), .HEIGHT(64), .O_W_WIDTH(128), .O_W_HEIGHT(36),
    .FIXED_BITW(16), .UNITS(4), .FIFO_DEPTH(64), .PRELOAD(32)
  ) u_main (
    .clock(clk), .rst(rst), .in_enable(m_en), .in_pixels(m_pix),
    .in_vcnt(m_vcnt), .in_hcnt(m_hcnt), .out_enable(m_oe), .out_pixels(m_opix),
    .out_vcnt(m_ov), .out_hcnt(m_oh), .overflow(m_ovf), .underflow(m_unf),
    .drop_count(m_drop)
  );

  pool_restreamer #(
    .WIDTH(64), .HEIGHT(64), .O_W_WIDTH(40), .O_W_HEIGHT(36),
    .FIXED_BITW(16), .UNITS(4), .FIFO_DEPTH(8), .PRELOAD(8)
  ) u_small (
    .clock(clk), .rst(rst), .in_enable(s_en), .in_pixels(s_pix),
    .in_vcnt(s_vcnt), .in_hcnt(s_hcnt), .out_enable(s_oe), .out_pixels(s_opix),
    .out_vcnt(s_ov), .out_hcnt(s_oh), .overflow(s_ovf), .underflow(s_unf),
    .drop_count(s_drop)
  );

  function automatic logic [0:63] pv(input int unsigned v);
    return {4{16'(v)}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the small instance for one cycle; returns at the next negedge.
  task automatic s_step(input logic en, input int unsigned v, input int unsigned h,
                        input int unsigned d);
    s_en   = en;
    s_vcnt = 5'(v);
    s_hcnt = 5'(h);
    s_pix  = pv(d);
    @(negedge clk);
  endtask

  initial begin
    burst_vec_t  vecs[4];
    int          first_t, oe_cnt, bad, nz, n_act;
    int unsigned exp_drops;
    logic [0:63] got[10];

    vecs[0] = '{1'b0, 20, IDLE, 8, 1'b1, 12};
    vecs[1] = '{1'b1, 20, RUN,  8, 1'b1, 1};
    vecs[2] = '{1'b1, 8,  WAIT, 8, 1'b0, 0};
    vecs[3] = '{1'b0, 3,  IDLE, 3, 1'b0, 0};

    rst = 1'b1;
    m_en = 1'b0; m_pix = '0; m_vcnt = '0; m_hcnt = '0;
    s_en = 1'b0; s_pix = '0; s_vcnt = '0; s_hcnt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst s_out_enable", 64'(s_oe), 0);
    check("rst s_out_pixels", s_opix, 0);
    check("rst s_out_vcnt", 64'(s_ov), 0);
    check("rst s_out_hcnt", 64'(s_oh), 0);
    check("rst s_overflow", 64'(s_ovf), 0);
    check("rst s_underflow", 64'(s_unf), 0);
    check("rst s_drop_count", 64'(s_drop), 0);
    check("rst s_state", 64'(u_small.state_q), 64'(IDLE));
    check("rst m_out_enable", 64'(m_oe), 0);
    check("rst m_out_pixels", m_opix, 0);
    rst = 1'b0;
    nz = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_oh != 0 || m_oh != 0 || s_oe || m_oe) nz++;
    end
    check("idle counters stay 0", 64'(nz), 0);

    // Full 32x32 pooled frame at the pooling cadence on the rate-matched instance
    oe_cnt = 0; bad = 0; first_t = -1;
    for (int t = 0; t < 4720; t++) begin
      int r, c;
      r = t / 64;
      c = t % 64;
      if (t < 4096 && (r % 2) == 0 && (c % 2) == 0) begin
        m_en = 1'b1; m_vcnt = 5'(r / 2); m_hcnt = 5'(c / 2); m_pix = pv((r / 2) * 32 + c / 2);
      end else begin
        m_en = 1'b0;
      end
      @(negedge clk);
      if (m_oe) begin
        if (first_t < 0) first_t = t;
        if (m_opix !== pv(oe_cnt) || m_ov !== 6'(oe_cnt / 32) || m_oh !== 7'(oe_cnt % 32)) bad++;
        oe_cnt++;
      end
    end
    check("frame first pixel cycle", 64'(first_t), 64);
    check("frame out_enable cycles", 64'(oe_cnt), 1024);
    check("frame pixel/position errors", 64'(bad), 0);
    check("frame overflow", 64'(m_ovf), 0);
    check("frame underflow", 64'(m_unf), 0);
    check("frame end state", 64'(u_main.state_q), 64'(IDLE));

    // Back-to-back bursts into the 8-deep FIFO
    for (int i = 0; i < 4; i++) begin
      rst = 1'b1; s_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < int'(vecs[i].n_push); j++) begin
        if (vecs[i].sof_first) s_step(1'b1, 0, j, 600 + j);
        else                   s_step(1'b1, 1, j, 600 + j);
      end
      s_en = 1'b0;
`ifdef POOL_RESTREAM_DROP_COUNT_EN
      exp_drops = vecs[i].exp_drops_en;
`else
      exp_drops = 0;
`endif
      check($sformatf("burst%0d state", i), 64'(u_small.state_q), 64'(vecs[i].exp_state));
      check($sformatf("burst%0d count", i), 64'(u_small.u_fifo.count_q), 64'(vecs[i].exp_count));
      check($sformatf("burst%0d overflow", i), 64'(s_ovf), 64'(vecs[i].exp_ovf));
      check($sformatf("burst%0d drop_count", i), 64'(s_drop), 64'(exp_drops));
    end

    // Second SOF during WAIT flushes the FIFO
    rst = 1'b1; s_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s_step(1'b1, 0, 0, 400);
    s_step(1'b1, 0, 1, 401);
    s_step(1'b1, 0, 2, 402);
    check("flush count before", 64'(u_small.u_fifo.count_q), 3);
    s_step(1'b1, 0, 0, 500);
    check("flush count after", 64'(u_small.u_fifo.count_q), 1);
    check("flush state", 64'(u_small.state_q), 64'(WAIT));
    for (int j = 1; j < 8; j++) s_step(1'b1, 0, j, 500 + j);
    first_t = -1;
    for (int t = 11; t < 40 && first_t < 0; t++) begin
      s_step(1'b0, 0, 0, 0);
      if (s_oe) first_t = t;
    end
    check("flush first pixel cycle", 64'(first_t), 12);
    check("flush first pixel", s_opix, pv(500));
    s_step(1'b0, 0, 0, 0);
    check("flush second pixel", s_opix, pv(501));
    check("flush overflow", 64'(s_ovf), 0);
    check("flush drop_count", 64'(s_drop), 0);

    // Input stalls after PRELOAD pixels -> underflow on the 9th pop
    rst = 1'b1; s_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) s_step(1'b1, 0, j, 200 + j);
    first_t = -1; n_act = 0;
    for (int t = 8; t < 60 && n_act < 10; t++) begin
      s_step(1'b0, 0, 0, 0);
      if (s_oe) begin
        if (first_t < 0) first_t = t;
        got[n_act] = s_opix;
        n_act++;
      end
    end
    check("stall active pixels seen", 64'(n_act), 10);
    check("stall first pixel cycle", 64'(first_t), 9);
    bad = 0;
    for (int j = 0; j < 8; j++) if (got[j] !== pv(200 + j)) bad++;
    check("stall buffered pixels", 64'(bad), 0);
    check("stall 9th pixel zero", got[8], 0);
    check("stall underflow", 64'(s_unf), 1);
    check("stall overflow", 64'(s_ovf), 0);

    // Reset mid-RUN at out_vcnt=5, then a clean restart
    for (int k = 0; k < 400 && s_ov != 6'd5; k++) s_step(1'b0, 0, 0, 0);
    check("midrun reached vcnt 5", 64'(s_ov), 5);
    rst = 1'b1; s_en = 1'b0;
    @(negedge clk);
    check("midrun rst out_enable", 64'(s_oe), 0);
    check("midrun rst out_pixels", s_opix, 0);
    check("midrun rst out_vcnt", 64'(s_ov), 0);
    check("midrun rst out_hcnt", 64'(s_oh), 0);
    check("midrun rst underflow", 64'(s_unf), 0);
    check("midrun rst state", 64'(u_small.state_q), 64'(IDLE));
    rst = 1'b0;
    for (int j = 0; j < 8; j++) s_step(1'b1, 0, j, 300 + j);
    first_t = -1;
    for (int t = 8; t < 40 && first_t < 0; t++) begin
      s_step(1'b0, 0, 0, 0);
      if (s_oe) first_t = t;
    end
    check("restart first pixel cycle", 64'(first_t), 9);
    check("restart out_vcnt", 64'(s_ov), 0);
    check("restart out_hcnt", 64'(s_oh), 0);
    check("restart pixel", s_opix, pv(300));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
